pa_f_spsram_bist: RTL
=====================

Name: pa_f_spsram_bist

Overview:
- March C- built-in self-test controller that drives the single-port SRAM interface (A, CEN, D, GWEN, WEN, Q) of the 256x40 array macro.
- Sits between the functional owner of the array and the macro.
- While idle, the functional interface passes straight through; while testing, the controller owns the array and compares read data.
- Reports pass/fail and the first failing location.

Parameters:
ADDR_WIDTH, 8, SRAM address width; array depth = 2**ADDR_WIDTH
DATA_WIDTH, 40, SRAM word width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
bist_start  input  1  single-cycle start request
bist_busy  output  1  test in progress (RUN or DRAIN)
bist_done  output  1  test finished; holds until next accepted start
bist_fail  output  1  sticky mismatch flag; valid with bist_done
bist_fail_addr  output  ADDR_WIDTH  address of first mismatch
bist_fail_elem  output  3  march element index (0-5) of first mismatch
func_a  input  ADDR_WIDTH  functional address
func_cen  input  1  functional chip enable, active-low
func_d  input  DATA_WIDTH  functional write data
func_gwen  input  1  functional global write enable, active-low
func_wen  input  DATA_WIDTH  functional bit write enables, active-low
func_q  output  DATA_WIDTH  read data to functional side (= Q, always)
A  output  ADDR_WIDTH  to SRAM
CEN  output  1  to SRAM
D  output  DATA_WIDTH  to SRAM
GWEN  output  1  to SRAM
WEN  output  DATA_WIDTH  to SRAM
Q  input  DATA_WIDTH  from SRAM

Behaviour:
- One clock CLK; reset RST asynchronous, active-high.
- Reset values: FSM=IDLE; bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0, bist_fail_elem=0; address counter 0; element 0; compare pipe invalid.
- SRAM mux: when bist_busy=0, A/CEN/D/GWEN/WEN = func_* combinationally. When bist_busy=1, the controller drives them and func_* are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN on bist_start=1. Entering RUN clears bist_done, bist_fail, fail_addr, fail_elem.
  - bist_start is ignored in RUN/DRAIN.
- March elements, each a full address sweep; "0" = all-zero word, "1" = all-one word:
  - E0: up w0
  - E1: up r0,w1
  - E2: up r1,w0
  - E3: down r0,w1
  - E4: down r1,w0
  - E5: up r0
- Up sweeps run 0 -> 2**ADDR_WIDTH-1; down sweeps run max -> 0. The address counter wraps, and the element advances on the terminal address.
- Each operation takes one cycle with CEN=0 and WEN=all 0:
  - Read: GWEN=1.
  - Write: GWEN=0, D=pattern.
  - A read and its write to the same address occupy consecutive cycles (r then w).
- Read compare:
  - A read issued in cycle N is compared against Q at the rising edge ending cycle N+1; expected value and address/element are pipelined one stage.
  - Mismatch on any bit sets bist_fail.
  - fail_addr/fail_elem are captured only if bist_fail was 0 (first failure wins).
  - The test continues to completion after a fail.
- Terminal condition: the last E5 read, at address max, moves the FSM to DRAIN for one cycle (CEN=1, final compare). The FSM then moves to DONE: bist_busy=0, bist_done=1.
- Duration at default size: RUN = 256 + 4*512 + 256 = 2560 cycles, plus 1 DRAIN cycle; bist_busy high for 2561 cycles.
- RST asserted mid-test returns to IDLE immediately; the mux reverts to func_* and results are cleared.
- bist_start in the same cycle as RST: reset wins.

Optional Feature:
PA_F_SPSRAM_BIST_DIAG_EN
- Defined, adds these outputs:
  - bist_fail_cnt [7:0]: saturating count of mismatching reads, cleared at start.
  - bist_fail_bits [DATA_WIDTH-1:0]: XOR of Q and expected for the first failing read, cleared at start.
- Not defined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Fault-free SRAM model, pulse bist_start -> bist_busy high exactly 2561 cycles, then bist_done=1, bist_fail=0.
- Stuck-at-1 on addr 0x5A bit 17 -> bist_fail=1, fail_addr=0x5A, fail_elem=1; with DIAG_EN, fail_bits=1<<17, fail_cnt=3 (E1, E3, E5 r0 reads).
- Stuck-at-0 on addr 0xFF bit 0 -> fail_addr=0xFF, fail_elem=2; first failure held despite later mismatches in E4.
- RST asserted at cycle 1000 of RUN -> all outputs 0 next cycle; CEN follows func_cen; a new start runs a full clean 2561-cycle test.
- bist_start pulsed while busy, and again in DONE -> ignored while busy; in DONE it restarts and clears bist_done/bist_fail.
- Idle passthrough: func_cen=0, func_gwen=0, func_a=0x33, func_d=0x12_3456_789A -> identical values on A/D/CEN/GWEN same cycle; func_q equals Q.

Source files
------------

// File: rtl/pa_f_spsram_bist.sv
// March C- BIST controller for the 256x40 single-port SRAM macro, with functional passthrough when idle.
// Optional diagnostics (fail count, first-fail bit map) are enabled by defining PA_F_SPSRAM_BIST_DIAG_EN.
module pa_f_spsram_bist #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 40
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  bist_start,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_fail,
   output logic [ADDR_WIDTH-1:0] bist_fail_addr,
   output logic [2:0]            bist_fail_elem,
`ifdef PA_F_SPSRAM_BIST_DIAG_EN
   output logic [7:0]            bist_fail_cnt,
   output logic [DATA_WIDTH-1:0] bist_fail_bits,
`endif
   input  logic [ADDR_WIDTH-1:0] func_a,
   input  logic                  func_cen,
   input  logic [DATA_WIDTH-1:0] func_d,
   input  logic                  func_gwen,
   input  logic [DATA_WIDTH-1:0] func_wen,
   output logic [DATA_WIDTH-1:0] func_q,
   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic [DATA_WIDTH-1:0] D,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   input  logic [DATA_WIDTH-1:0] Q
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] ALL_ONE   = {DATA_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] ALL_ZERO  = {DATA_WIDTH{1'b0}};

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [2:0]              elem_r;
   logic                    phase_r;
   logic                    cmp_vld_r;
   logic [DATA_WIDTH-1:0]   cmp_exp_r;
   logic [ADDR_WIDTH-1:0]   cmp_addr_r;
   logic [2:0]              cmp_elem_r;

   logic                    rd_s;
   logic                    wr_one_s;
   logic                    exp_one_s;
   logic                    down_s;
   logic                    single_s;
   logic                    last_op_s;
   logic                    term_s;
   logic [2:0]              nxt_elem_s;
   logic [ADDR_WIDTH-1:0]   nxt_start_s;
   logic                    run_s;

   // Decode the current march element into operation type, data polarity and sweep direction.
   always_comb begin
      rd_s      = 1'b0;
      wr_one_s  = 1'b0;
      exp_one_s = 1'b0;
      down_s    = 1'b0;
      single_s  = 1'b0;
      case (elem_r)
         3'd0: single_s = 1'b1;
         3'd1: begin rd_s = ~phase_r; wr_one_s = 1'b1; end
         3'd2: begin rd_s = ~phase_r; exp_one_s = 1'b1; end
         3'd3: begin rd_s = ~phase_r; wr_one_s = 1'b1; down_s = 1'b1; end
         3'd4: begin rd_s = ~phase_r; exp_one_s = 1'b1; down_s = 1'b1; end
         3'd5: begin rd_s = 1'b1; single_s = 1'b1; end
         default: single_s = 1'b1;
      endcase
      last_op_s   = single_s | phase_r;
      term_s      = down_s ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);
      nxt_elem_s  = elem_r + 3'd1;
      nxt_start_s = ((nxt_elem_s == 3'd3) || (nxt_elem_s == 3'd4)) ? ADDR_MAX : ADDR_ZERO;
      run_s       = (state_r == ST_RUN);
   end

   // SRAM port mux: functional side when idle, controller otherwise (CEN high during drain).
   always_comb begin
      if (bist_busy) begin
         A    = addr_r;
         CEN  = ~run_s;
         D    = wr_one_s ? ALL_ONE : ALL_ZERO;
         GWEN = rd_s | ~run_s;
         WEN  = ALL_ZERO;
      end else begin
         A    = func_a;
         CEN  = func_cen;
         D    = func_d;
         GWEN = func_gwen;
         WEN  = func_wen;
      end
   end

   assign func_q = Q;

   // Controller FSM, address/element sequencing and one-stage read compare pipe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r        <= ST_IDLE;
         bist_busy      <= 1'b0;
         bist_done      <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= ADDR_ZERO;
         bist_fail_elem <= 3'd0;
         addr_r         <= ADDR_ZERO;
         elem_r         <= 3'd0;
         phase_r        <= 1'b0;
         cmp_vld_r      <= 1'b0;
         cmp_exp_r      <= ALL_ZERO;
         cmp_addr_r     <= ADDR_ZERO;
         cmp_elem_r     <= 3'd0;
`ifdef PA_F_SPSRAM_BIST_DIAG_EN
         bist_fail_cnt  <= 8'd0;
         bist_fail_bits <= ALL_ZERO;
`endif
      end else begin
         if (cmp_vld_r && (Q != cmp_exp_r)) begin
            bist_fail <= 1'b1;
            if (!bist_fail) begin
               bist_fail_addr <= cmp_addr_r;
               bist_fail_elem <= cmp_elem_r;
`ifdef PA_F_SPSRAM_BIST_DIAG_EN
               bist_fail_bits <= Q ^ cmp_exp_r;
`endif
            end
`ifdef PA_F_SPSRAM_BIST_DIAG_EN
            if (bist_fail_cnt != 8'hFF) begin
               bist_fail_cnt <= bist_fail_cnt + 8'd1;
            end
`endif
         end
         cmp_vld_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               // Start clears results; placed after the compare so it takes precedence.
               if (bist_start) begin
                  state_r        <= ST_RUN;
                  bist_busy      <= 1'b1;
                  bist_done      <= 1'b0;
                  bist_fail      <= 1'b0;
                  bist_fail_addr <= ADDR_ZERO;
                  bist_fail_elem <= 3'd0;
                  addr_r         <= ADDR_ZERO;
                  elem_r         <= 3'd0;
                  phase_r        <= 1'b0;
`ifdef PA_F_SPSRAM_BIST_DIAG_EN
                  bist_fail_cnt  <= 8'd0;
                  bist_fail_bits <= ALL_ZERO;
`endif
               end
            end
            ST_RUN: begin
               cmp_vld_r  <= rd_s;
               cmp_exp_r  <= exp_one_s ? ALL_ONE : ALL_ZERO;
               cmp_addr_r <= addr_r;
               cmp_elem_r <= elem_r;
               if (!last_op_s) begin
                  phase_r <= 1'b1;
               end else begin
                  phase_r <= 1'b0;
                  if (term_s) begin
                     if (elem_r == 3'd5) begin
                        state_r <= ST_DRAIN;
                     end else begin
                        elem_r <= nxt_elem_s;
                        addr_r <= nxt_start_s;
                     end
                  end else begin
                     addr_r <= down_s ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                  end
               end
            end
            ST_DRAIN: begin
               state_r   <= ST_DONE;
               bist_busy <= 1'b0;
               bist_done <= 1'b1;
            end
            default: begin
               state_r   <= ST_IDLE;
               bist_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
